// File: rtl/decrypt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_pkg
// Description : Shared types and constants for the receiver-side image
//               decryption sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package decrypt_pkg;

    // Bits per colour channel
    localparam int DATA_W         = 8;
    // Default pixel address width and frame size
    localparam int ADDR_W_DEF     = 14;
    localparam int NUM_PIXELS_DEF = 16384;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rgb_xor_stage.sv
`default_nettype none
// ============================================================================
// Module      : rgb_xor_stage
// Description : Registered 3-channel XOR of ciphertext and keystream bytes.
//               The result is loaded on entry to WRITE and held until the
//               next load, so the plaintext outputs are glitch-free.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_xor_stage
    import decrypt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] ct_r,
    input  logic [DATA_W-1:0] ct_g,
    input  logic [DATA_W-1:0] ct_b,
    input  logic [DATA_W-1:0] key_r,
    input  logic [DATA_W-1:0] key_g,
    input  logic [DATA_W-1:0] key_b,
    output logic [DATA_W-1:0] pt_r,
    output logic [DATA_W-1:0] pt_g,
    output logic [DATA_W-1:0] pt_b
);

    logic [DATA_W-1:0] r_pt_r;
    logic [DATA_W-1:0] r_pt_g;
    logic [DATA_W-1:0] r_pt_b;

    // Capture the decrypted pixel when the sequencer commits to a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pt_r <= '0;
            r_pt_g <= '0;
            r_pt_b <= '0;
        end else if (load) begin
            r_pt_r <= ct_r ^ key_r;
            r_pt_g <= ct_g ^ key_g;
            r_pt_b <= ct_b ^ key_b;
        end
    end

    assign pt_r = r_pt_r;
    assign pt_g = r_pt_g;
    assign pt_b = r_pt_b;

endmodule
`default_nettype wire

// File: rtl/decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_sequencer
// Description : Steps a pixel address across the ciphertext RGB memories,
//               requests one keystream triple per pixel and writes
//               (ciphertext XOR key) into the plaintext RGB memories.
//               FETCH / WAIT / WRITE per pixel, start/abort/done control.
// Revision    : 1.0 - initial release
// ============================================================================
module decrypt_sequencer
    import decrypt_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NUM_PIXELS = NUM_PIXELS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pix_count,
    output logic              key_req,
    input  logic              key_valid,
    input  logic [DATA_W-1:0] key_r,
    input  logic [DATA_W-1:0] key_g,
    input  logic [DATA_W-1:0] key_b,
    output logic              ct_rd_en,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [DATA_W-1:0] ct_r,
    input  logic [DATA_W-1:0] ct_g,
    input  logic [DATA_W-1:0] ct_b,
    output logic              pt_wr_en,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [DATA_W-1:0] pt_r,
    output logic [DATA_W-1:0] pt_g,
    output logic [DATA_W-1:0] pt_b
);

    // Address of the final pixel; the counter never steps past it
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_PIXELS - 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nx;
    logic [ADDR_W:0]     r_pix_count;
    logic                r_busy;
    logic                r_done;
    logic                r_key_req;
    logic                r_ct_rd_en;
    logic [ADDR_W-1:0]   r_ct_addr;
    logic                r_pt_wr_en;
    logic [ADDR_W-1:0]   r_pt_addr;
    logic [DATA_W-1:0]   r_ct_hold  [3];
    logic [DATA_W-1:0]   r_key_hold [3];
    logic                r_ct_got;
    logic                r_key_got;
    logic                w_xfer;
    logic                w_ct_cap;
    logic                w_restart;
    logic                w_xor_load;
    logic [DATA_W-1:0]   w_ct_src   [3];
    logic [DATA_W-1:0]   w_key_src  [3];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and next-address decode; abort overrides everything
    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_restart  = 1'b0;
        // A key only transfers while the request is actually outstanding
        w_xfer     = r_key_req & key_valid;
        // Ciphertext is valid on the first WAIT cycle only
        w_ct_cap   = (r_state == WAIT) & ~r_ct_got;
        if (abort) begin
            w_state_nx = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_state_nx = FETCH;
                        w_addr_nx  = '0;
                        w_restart  = 1'b1;
                    end
                end
                FETCH: w_state_nx = WAIT;
                WAIT: begin
                    if ((r_ct_got | w_ct_cap) & (r_key_got | w_xfer)) begin
                        w_state_nx = WRITE;
                    end
                end
                WRITE: begin
                    if (r_addr == c_LAST) begin
                        w_state_nx = DONE;
                    end else begin
                        w_state_nx = FETCH;
                        w_addr_nx  = r_addr + 1'b1;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // XOR operands: take the live bus when the capture completes this cycle
    always_comb begin
        w_ct_src[0]  = r_ct_got  ? r_ct_hold[0]  : ct_r;
        w_ct_src[1]  = r_ct_got  ? r_ct_hold[1]  : ct_g;
        w_ct_src[2]  = r_ct_got  ? r_ct_hold[2]  : ct_b;
        w_key_src[0] = r_key_got ? r_key_hold[0] : key_r;
        w_key_src[1] = r_key_got ? r_key_hold[1] : key_g;
        w_key_src[2] = r_key_got ? r_key_hold[2] : key_b;
        w_xor_load   = (r_state == WAIT) & (w_state_nx == WRITE);
    end

    // Registered outputs, address/pixel counters and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= '0;
            r_pix_count   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_key_req     <= 1'b0;
            r_ct_rd_en    <= 1'b0;
            r_ct_addr     <= '0;
            r_pt_wr_en    <= 1'b0;
            r_pt_addr     <= '0;
            r_ct_hold[0]  <= '0;
            r_ct_hold[1]  <= '0;
            r_ct_hold[2]  <= '0;
            r_key_hold[0] <= '0;
            r_key_hold[1] <= '0;
            r_key_hold[2] <= '0;
            r_ct_got      <= 1'b0;
            r_key_got     <= 1'b0;
        end else begin
            r_addr     <= w_addr_nx;
            r_busy     <= (w_state_nx == FETCH) | (w_state_nx == WAIT) |
                          (w_state_nx == WRITE);
            r_done     <= (w_state_nx == DONE);
            r_ct_rd_en <= (w_state_nx == FETCH);
            r_pt_wr_en <= (w_state_nx == WRITE);
            // Request raised leaving FETCH, held through WAIT until transfer
            r_key_req  <= (w_state_nx == WAIT) &
                          ((r_state == FETCH) | (r_key_req & ~w_xfer));
            if (w_state_nx == FETCH) begin
                r_ct_addr <= w_addr_nx;
            end
            if (w_state_nx == WRITE) begin
                r_pt_addr <= r_addr;
            end
            if (w_restart) begin
                r_pix_count <= '0;
            end else if ((r_state == WRITE) && !abort) begin
                r_pix_count <= r_pix_count + 1'b1;
            end
            if (r_state == FETCH) begin
                r_ct_got  <= 1'b0;
                r_key_got <= 1'b0;
            end else if (r_state == WAIT) begin
                if (w_ct_cap) begin
                    r_ct_hold[0] <= ct_r;
                    r_ct_hold[1] <= ct_g;
                    r_ct_hold[2] <= ct_b;
                    r_ct_got     <= 1'b1;
                end
                if (w_xfer) begin
                    r_key_hold[0] <= key_r;
                    r_key_hold[1] <= key_g;
                    r_key_hold[2] <= key_b;
                    r_key_got     <= 1'b1;
                end
            end
        end
    end

    rgb_xor_stage u_xor (
        .clk   (clk),
        .rst   (rst),
        .load  (w_xor_load),
        .ct_r  (w_ct_src[0]),
        .ct_g  (w_ct_src[1]),
        .ct_b  (w_ct_src[2]),
        .key_r (w_key_src[0]),
        .key_g (w_key_src[1]),
        .key_b (w_key_src[2]),
        .pt_r  (pt_r),
        .pt_g  (pt_g),
        .pt_b  (pt_b)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign pix_count = r_pix_count;
    assign key_req   = r_key_req;
    assign ct_rd_en  = r_ct_rd_en;
    assign ct_addr   = r_ct_addr;
    assign pt_wr_en  = r_pt_wr_en;
    assign pt_addr   = r_pt_addr;

endmodule
`default_nettype wire

// File: tb/tb_decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decrypt_sequencer
// Description : Self-checking bench for decrypt_sequencer: 16-pixel main
//               instance plus 1-pixel and 16384-pixel instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decrypt_sequencer;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic start_x = 1'b0, abort_x = 1'b0, key_valid = 1'b0;
    logic [7:0] key_r = '0, key_g = '0, key_b = '0;

    logic busy, done, key_req, ct_rd_en, pt_wr_en;
    logic [3:0] ct_addr, pt_addr;
    logic [4:0] pix_count;
    logic [7:0] ct_r = '0, ct_g = '0, ct_b = '0, pt_r, pt_g, pt_b;

    logic busy_1, done_1, key_req_1, ct_rd_en_1, pt_wr_en_1;
    logic [3:0] ct_addr_1, pt_addr_1;
    logic [4:0] pix_count_1;
    logic [7:0] ct_r_1 = '0, ct_g_1 = '0, ct_b_1 = '0, pt_r_1, pt_g_1, pt_b_1;

    logic busy_b, done_b, key_req_b, ct_rd_en_b, pt_wr_en_b;
    logic [13:0] ct_addr_b, pt_addr_b;
    logic [14:0] pix_count_b;
    logic [7:0] ct_r_b = '0, ct_g_b = '0, ct_b_b = '0, pt_r_b, pt_g_b, pt_b_b;

    decrypt_sequencer #(.ADDR_W(4), .NUM_PIXELS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .pix_count(pix_count), .key_req(key_req), .key_valid(key_valid),
        .key_r(key_r), .key_g(key_g), .key_b(key_b), .ct_rd_en(ct_rd_en), .ct_addr(ct_addr),
        .ct_r(ct_r), .ct_g(ct_g), .ct_b(ct_b), .pt_wr_en(pt_wr_en), .pt_addr(pt_addr),
        .pt_r(pt_r), .pt_g(pt_g), .pt_b(pt_b));

    decrypt_sequencer #(.ADDR_W(4), .NUM_PIXELS(1)) dut_1 (
        .clk(clk), .rst(rst), .start(start_x), .abort(abort_x), .busy(busy_1), .done(done_1),
        .pix_count(pix_count_1), .key_req(key_req_1), .key_valid(key_valid),
        .key_r(key_r), .key_g(key_g), .key_b(key_b), .ct_rd_en(ct_rd_en_1), .ct_addr(ct_addr_1),
        .ct_r(ct_r_1), .ct_g(ct_g_1), .ct_b(ct_b_1), .pt_wr_en(pt_wr_en_1), .pt_addr(pt_addr_1),
        .pt_r(pt_r_1), .pt_g(pt_g_1), .pt_b(pt_b_1));

    decrypt_sequencer #(.ADDR_W(14), .NUM_PIXELS(16384)) dut_b (
        .clk(clk), .rst(rst), .start(start_x), .abort(abort_x), .busy(busy_b), .done(done_b),
        .pix_count(pix_count_b), .key_req(key_req_b), .key_valid(key_valid),
        .key_r(key_r), .key_g(key_g), .key_b(key_b), .ct_rd_en(ct_rd_en_b), .ct_addr(ct_addr_b),
        .ct_r(ct_r_b), .ct_g(ct_g_b), .ct_b(ct_b_b), .pt_wr_en(pt_wr_en_b), .pt_addr(pt_addr_b),
        .pt_r(pt_r_b), .pt_g(pt_g_b), .pt_b(pt_b_b));

    always #5 clk = ~clk;

    // Ciphertext content for an address: r = addr, g = addr^3C, b = ~addr
    function automatic logic [23:0] ct_of(input logic [13:0] a);
        ct_of = {a[7:0], a[7:0] ^ 8'h3C, ~a[7:0]};
    endfunction

    // 1-cycle-latency ciphertext RAMs; bus shows junk when not freshly read
    always @(posedge clk) begin
        {ct_r, ct_g, ct_b}       <= ct_rd_en   ? ct_of({10'd0, ct_addr})   : 24'hEEEEEE;
        {ct_r_1, ct_g_1, ct_b_1} <= ct_rd_en_1 ? ct_of({10'd0, ct_addr_1}) : 24'hEEEEEE;
        {ct_r_b, ct_g_b, ct_b_b} <= ct_rd_en_b ? ct_of(ct_addr_b)          : 24'hEEEEEE;
    end

    typedef struct {
        logic [7:0]  kr, kg, kb;
        logic [23:0] exp;
    } vec_t;
    typedef struct packed {
        logic [3:0]  a;
        logic [23:0] d;
    } exp_t;

    vec_t        tbl [16];
    exp_t        sb [$];
    logic [23:0] ptm [16];
    int total = 0, bad = 0;
    int xfer_cnt = 0, n_writes = 0, busy_cnt = 0, key_mode = 0, dly = 0;
    int w1 = 0, wb = 0, last1 = -1, lastb = -1;
    logic waiting = 1'b0, one_ok = 1'b1, b_ok = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: scoreboard push on key transfer, pop/compare on write
    task automatic step();
        logic xf, ab;
        logic [23:0] k;
        exp_t e;
        xf = key_req & key_valid;
        ab = abort | rst;
        k  = {key_r, key_g, key_b};
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (ab || rst) waiting = 1'b0;
        if (xf) begin
            e.a = xfer_cnt[3:0];
            e.d = ct_of(14'(xfer_cnt)) ^ k;
            sb.push_back(e);
            xfer_cnt++;
            waiting = 1'b0;
        end
        if (pt_wr_en) begin
            n_writes++;
            chk("key_before_write", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pt_addr", pt_addr, e.a);
                chk("pt_data", {pt_r, pt_g, pt_b}, e.d);
            end
            ptm[pt_addr] = {pt_r, pt_g, pt_b};
        end
        if (key_req) chk("key_req_only_in_wait", {ct_rd_en, pt_wr_en, done, busy}, 4'b0001);
        if (waiting) chk("key_req_held", key_req, 1);
        if (ct_rd_en) waiting = 1'b1;
        if (pt_wr_en_1) begin
            if ({pt_r_1, pt_g_1, pt_b_1} != (ct_of({10'd0, pt_addr_1}) ^ {key_r, key_g, key_b}))
                one_ok = 1'b0;
            w1++;
            last1 = int'(pt_addr_1);
        end
        if (pt_wr_en_b) begin
            if (int'(pt_addr_b) != wb) b_ok = 1'b0;
            if ({pt_r_b, pt_g_b, pt_b_b} != (ct_of(pt_addr_b) ^ {key_r, key_g, key_b}))
                b_ok = 1'b0;
            wb++;
            lastb = int'(pt_addr_b);
        end
        case (key_mode)
            0: begin
                key_valid = 1'b1;
                {key_r, key_g, key_b} = {tbl[xfer_cnt % 16].kr, tbl[xfer_cnt % 16].kg,
                                         tbl[xfer_cnt % 16].kb};
            end
            1: begin
                {key_r, key_g, key_b} = 24'($urandom);
                if (key_req) begin
                    if (dly == 0) begin
                        key_valid = 1'b1;
                        dly = $urandom_range(0, 7);
                    end else begin
                        key_valid = 1'b0;
                        dly--;
                    end
                end else begin
                    key_valid = 1'($urandom_range(0, 1));
                end
            end
            default: ;
        endcase
    endtask

    task automatic start_pass();
        sb.delete();
        xfer_cnt = 0;
        n_writes = 0;
        busy_cnt = 0;
        waiting  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        chk("pass_done", done, 1);
    endtask

    initial begin
        int wn;
        for (int i = 0; i < 16; i++) begin
            tbl[i].kr  = 8'hA5;
            tbl[i].kg  = 8'h5A ^ 8'(i);
            tbl[i].kb  = 8'hC3 + 8'(i);
            tbl[i].exp = {8'(i) ^ 8'hA5, (8'(i) ^ 8'h3C) ^ tbl[i].kg, ~8'(i) ^ tbl[i].kb};
        end

        // Reset state
        step();
        step();
        chk("rst_main", {busy, done, key_req, ct_rd_en, pt_wr_en, ct_addr, pt_addr,
                         pix_count, pt_r, pt_g, pt_b}, 0);
        chk("rst_aux", {busy_1, done_1, key_req_1, pt_wr_en_1, busy_b, done_b,
                        key_req_b, pt_wr_en_b, pix_count_b}, 0);
        rst = 1'b0;
        step();

        // 1: key always valid, full pass at 3 cycles/pixel
        key_mode = 0;
        start_pass();
        run_to_done(200);
        chk("t1_busy_cycles", busy_cnt, 48);
        chk("t1_pix_count", pix_count, 16);
        chk("t1_writes", n_writes, 16);
        for (int i = 0; i < 16; i++) chk("t1_pt_mem", ptm[i], tbl[i].exp);
        repeat (3) step();
        chk("t1_done_held", done, 1);
        chk("t1_no_extra_write", n_writes, 16);

        // 2: random key latency 0..7, random junk on key bus
        key_mode = 1;
        dly = $urandom_range(0, 7);
        start_pass();
        run_to_done(2000);
        chk("t2_writes", n_writes, 16);
        chk("t2_pix_count", pix_count, 16);
        chk("t2_sb_empty", sb.size(), 0);

        // 3: abort while waiting on pixel 5, then full restart
        key_mode = 0;
        start_pass();
        for (int i = 0; i < 200 && n_writes < 5; i++) step();
        step();
        chk("t3_fetch_px5", {ct_rd_en, ct_addr}, {1'b1, 4'd5});
        step();
        chk("t3_wait_px5", key_req, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_abort_outs", {busy, done, key_req, ct_rd_en, pt_wr_en}, 0);
        chk("t3_pix_count", pix_count, 5);
        wn = n_writes;
        repeat (8) step();
        chk("t3_no_write_after_abort", n_writes, wn);
        chk("t3_idle", busy, 0);
        start_pass();
        chk("t3_restart_addr", ct_addr, 0);
        run_to_done(200);
        chk("t3_writes", n_writes, 16);
        chk("t3_busy_cycles", busy_cnt, 48);

        // 4: start while busy is ignored; start & abort together -> IDLE
        start_pass();
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done(200);
        chk("t4_writes", n_writes, 16);
        chk("t4_busy_cycles", busy_cnt, 48);
        chk("t4_pix_count", pix_count, 16);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("t4_start_abort", {busy, done, ct_rd_en}, 0);
        repeat (3) step();
        chk("t4_stays_idle", busy, 0);

        // 5: asynchronous reset mid-WAIT, then clean pass
        key_mode = 1;
        start_pass();
        for (int i = 0; i < 400 && !(n_writes >= 3 && key_req); i++) step();
        chk("t5_in_wait", key_req, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_rst", {busy, done, key_req, ct_rd_en, pt_wr_en, ct_addr, pt_addr,
                             pix_count, pt_r, pt_g, pt_b}, 0);
        step();
        step();
        rst = 1'b0;
        start_pass();
        run_to_done(2000);
        chk("t5_writes", n_writes, 16);
        chk("t5_pix_count", pix_count, 16);

        // 6: frame-size extremes, 1 and 16384 pixels
        key_mode = 2;
        key_valid = 1'b1;
        {key_r, key_g, key_b} = 24'h112233;
        start_x = 1'b1;
        step();
        start_x = 1'b0;
        for (int i = 0; i < 50000 && !(done_1 && done_b); i++) step();
        chk("t6_one_writes", w1, 1);
        chk("t6_one_last", last1, 0);
        chk("t6_one_done", {done_1, pix_count_1}, {1'b1, 5'd1});
        chk("t6_one_data", one_ok, 1);
        chk("t6_big_writes", wb, 16384);
        chk("t6_big_last", lastb, 16383);
        chk("t6_big_done", {done_b, pix_count_b}, {1'b1, 15'd16384});
        chk("t6_big_seq_data", b_ok, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
